// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array and its SRAM write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

    localparam int SYS_N       = 4;
    localparam int SYS_ACC_W   = 20;
    localparam int SRAM_ADDR_W = 13;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_DEPTH  = 1 << SRAM_ADDR_W;

    typedef logic signed [SYS_ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/systolic_result_writer_if.sv
// Write-back request (start/base/matrix) plus status and SRAM write-port bundle.
// Latency: n/a (wires only).
// Backpressure: none; the SRAM write port always accepts.
interface systolic_result_writer_if
    import systolic_pkg::*;
#(
    parameter int N      = SYS_N,
    parameter int ACC_W  = SYS_ACC_W,
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) ();

    logic                             start;
    logic [ADDR_W-1:0]                base_addr;
    logic [N-1:0][N-1:0][ACC_W-1:0]   out;
    logic                             busy;
    logic                             done;
    logic                             wsbn;
    logic [ADDR_W-1:0]                waddr;
    logic [DATA_W-1:0]                wdata;

    // The writer drives the SRAM write port and status.
    modport master (
        input  start,
        input  base_addr,
        input  out,
        output busy,
        output done,
        output wsbn,
        output waddr,
        output wdata
    );

    modport slave (
        output start,
        output base_addr,
        output out,
        input  busy,
        input  done,
        input  wsbn,
        input  waddr,
        input  wdata
    );

endinterface

// File: rtl/systolic_result_writer.sv
// Snapshots the NxN accumulator matrix and writes it row-major, one word per cycle, to SRAM.
// Latency: first write one cycle after start is sampled; done N*N+1 cycles after the start edge.
// Backpressure: none; start is ignored while busy and never queued.
module systolic_result_writer
    import systolic_pkg::*;
#(
    parameter int N      = SYS_N,
    parameter int ACC_W  = SYS_ACC_W,
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    systolic_result_writer_if.master wb
);

    localparam int              NN       = N * N;
    localparam int              IDX_W    = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    wb_state_t                 r_state;
    wb_state_t                 w_state_nxt;

    logic [NN-1:0][ACC_W-1:0]  r_snap;
    logic [ADDR_W-1:0]         r_base;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic                      r_busy;
    logic                      w_busy_nxt;
    logic                      r_done;
    logic                      w_done_nxt;
    logic                      r_wsbn;
    logic                      w_wsbn_nxt;
    logic [ADDR_W-1:0]         r_waddr;
    logic [ADDR_W-1:0]         w_waddr_nxt;
    logic [DATA_W-1:0]         r_wdata;
    logic [DATA_W-1:0]         w_wdata_nxt;
    logic                      w_load;
    logic signed [ACC_W-1:0]   w_elem;

    // Flattened snapshot index idx == r*N + c, so this is out[idx/N][idx%N].
    assign w_elem = r_snap[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_wsbn_nxt  = 1'b1;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_load      = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (wb.start) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                w_wsbn_nxt  = 1'b0;
                // Address add truncates to ADDR_W, so bursts wrap past the top silently.
                w_waddr_nxt = r_base + ADDR_W'(r_idx);
                w_wdata_nxt = DATA_W'(w_elem);
                w_idx_nxt   = r_idx + IDX_W'(1);
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap  <= '0;
            r_base  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wsbn  <= 1'b1;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_wsbn  <= w_wsbn_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            if (w_load) begin
                r_snap <= wb.out;
                r_base <= wb.base_addr;
            end
        end
    end

    assign wb.busy  = r_busy;
    assign wb.done  = r_done;
    assign wb.wsbn  = r_wsbn;
    assign wb.waddr = r_waddr;
    assign wb.wdata = r_wdata;

endmodule

// File: tb/tb_systolic_result_writer.sv
// Randomized scoreboard bench for systolic_result_writer against a row-major SRAM image model.
// Latency: n/a. Backpressure: n/a.
module tb_systolic_result_writer;
    import systolic_pkg::*;

    localparam int N      = 4;
    localparam int ACC_W  = 20;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int NN     = N * N;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    systolic_result_writer_if #(.N(N), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

    systolic_result_writer #(.N(N), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        mem [SRAM_DEPTH];
    logic [ACC_W-1:0]         mat [N][N];

    function automatic void chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Two's-complement value of the accumulator, re-expressed as a 32-bit word.
    function automatic logic [DATA_W-1:0] sext(input logic [ACC_W-1:0] v);
        longint s;
        s = longint'(v);
        if (v[ACC_W-1]) s = s - (longint'(1) << ACC_W);
        return DATA_W'(s);
    endfunction

    task automatic push_expected(input logic [ADDR_W-1:0] base);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int a;
                a = (int'(base) + r * N + c) % SRAM_DEPTH;
                exp_q.push_back({ADDR_W'(a), sext(mat[r][c])});
            end
        end
    endtask

    task automatic rand_mat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = ACC_W'($urandom);
    endtask

    task automatic drive_req(input logic [ADDR_W-1:0] base);
        wb.base_addr = base;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wb.out[r][c] = mat[r][c];
        wb.start = 1'b1;
    endtask

    // Monitor: pops one expected write per cycle the SRAM strobe is active.
    always @(negedge clk) begin
        if (rst_n && wb.wsbn == 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got write addr 0x%0h data 0x%0h, required no write (t=%0t)",
                         wb.waddr, wb.wdata, $time);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(wb.waddr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
                chk("write_data", 64'(wb.wdata), 64'(e[DATA_W-1:0]));
                mem[wb.waddr] = wb.wdata;
            end
        end
    end

    // mode 0: plain burst; 1: disturb inputs and re-pulse start mid-burst; 2: reset after 5th write
    task automatic burst(input logic [ADDR_W-1:0] base, input int mode);
        bit got_done;
        got_done = 1'b0;
        drive_req(base);
        @(posedge clk);
        push_expected(base);
        for (int k = 0; k < 40 && !got_done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                wb.start = 1'b0;
                chk("busy_after_start", 64'(wb.busy), 64'(1));
            end
            if (mode == 1 && k == 3) begin
                wb.base_addr = ADDR_W'($urandom);
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        wb.out[r][c] = ACC_W'($urandom);
                wb.start = 1'b1;
            end
            if (mode == 1 && k == 4) wb.start = 1'b0;
            if (mode == 2 && k == 5) begin
                #1 rst_n = 1'b0;
                #1;
                chk("reset_wsbn", 64'(wb.wsbn), 64'(1));
                chk("reset_busy", 64'(wb.busy), 64'(0));
                chk("reset_done", 64'(wb.done), 64'(0));
                chk("writes_before_reset", 64'(exp_q.size()), 64'(NN - 5));
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                for (int j = 0; j < 20; j++) begin
                    @(negedge clk);
                    chk("no_done_after_reset", 64'(wb.done), 64'(0));
                    chk("idle_wsbn_after_reset", 64'(wb.wsbn), 64'(1));
                end
                return;
            end
            if (wb.done) begin
                got_done = 1'b1;
                chk("done_latency", 64'(k), 64'(NN + 1));
                chk("writes_complete_at_done", 64'(exp_q.size()), 64'(0));
                chk("busy_at_done", 64'(wb.busy), 64'(0));
                chk("wsbn_at_done", 64'(wb.wsbn), 64'(1));
            end
        end
        if (!got_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done within 40 cycles, required done (t=%0t)", $time);
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(wb.done), 64'(0));
        chk("busy_after_done", 64'(wb.busy), 64'(0));
    endtask

    task automatic back_to_back();
        logic [ADDR_W-1:0] base1, base2;
        int first_done, second_done, n_done;
        first_done  = -1;
        second_done = -1;
        n_done      = 0;
        base1 = ADDR_W'($urandom);
        base2 = ADDR_W'($urandom);
        rand_mat();
        drive_req(base1);
        @(posedge clk);
        push_expected(base1);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 0) begin
                rand_mat();
                drive_req(base2);
                push_expected(base2);
            end
            if (k == NN + 1) chk("b2b_gap_done_wsbn", 64'(wb.wsbn), 64'(1));
            if (k == NN + 2) begin
                chk("b2b_gap_idle_wsbn", 64'(wb.wsbn), 64'(1));
                wb.start = 1'b0;
            end
            if (k == NN + 3) chk("b2b_second_first_write", 64'(wb.wsbn), 64'(0));
            if (wb.done) begin
                n_done++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        chk("b2b_done1", 64'(first_done), 64'(NN + 1));
        chk("b2b_done2", 64'(second_done), 64'(2 * NN + 3));
        chk("b2b_done_count", 64'(n_done), 64'(2));
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] b;
        rst_n        = 1'b0;
        wb.start     = 1'b0;
        wb.base_addr = '0;
        wb.out       = '0;
        for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy_init",  64'(wb.busy),  64'(0));
        chk("reset_done_init",  64'(wb.done),  64'(0));
        chk("reset_wsbn_init",  64'(wb.wsbn),  64'(1));
        chk("reset_waddr_init", 64'(wb.waddr), 64'(0));
        chk("reset_wdata_init", 64'(wb.wdata), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = ACC_W'(r * 16 + c);
        burst(13'h100, 0);
        chk("basic_word_0x105", 64'(mem[13'h105]), 64'(32'h0000_0011));

        rand_mat();
        mat[0][0] = 20'hFFFFF;
        mat[3][3] = 20'h80000;
        burst(13'h000, 0);
        chk("neg_minus_one", 64'(mem[13'h000]), 64'(32'hFFFF_FFFF));
        chk("neg_most_negative", 64'(mem[13'h00F]), 64'(32'hFFF8_0000));

        rand_mat();
        burst(13'h1FFE, 0);
        chk("wrap_last_word", 64'(mem[13'h000D]), 64'(sext(mat[3][3])));

        rand_mat();
        burst(ADDR_W'($urandom), 1);

        rand_mat();
        burst(ADDR_W'($urandom), 2);
        rand_mat();
        burst(ADDR_W'($urandom), 0);

        for (int i = 0; i < 6; i++) begin
            rand_mat();
            b = ADDR_W'($urandom);
            burst(b, 0);
        end

        back_to_back();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
